// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - shared state type, byte type and defaults for the SPI transfer sequencer
package spi_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } seq_state_e;

  typedef logic [7:0] byte_t;

  localparam int SPI_SEQ_DEF_DEPTH   = 8;
  localparam int SPI_SEQ_DEF_TIMEOUT = 1024;

endpackage

// File: rtl/spi_seq_fifo.sv
// rtl/spi_seq_fifo.sv - show-ahead synchronous FIFO with occupancy level
// Pointers carry one extra MSB so full and empty are told apart without a counter.
module spi_seq_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rptr[AW-1:0]];
  assign o_level   = r_wptr - r_rptr;

endmodule

// File: rtl/spi_xfer_sequencer.sv
// rtl/spi_xfer_sequencer.sv - byte-stream front end that launches one SPI master transfer per TX byte
// Optional SPI_SEQ_XFER_CNT_EN adds the xfer_count completed-transfer counter output.
module spi_xfer_sequencer
  import spi_seq_pkg::*;
#(
  parameter  int DEPTH   = SPI_SEQ_DEF_DEPTH,
  parameter  int TIMEOUT = SPI_SEQ_DEF_TIMEOUT,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [7:0]    tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic [CW-1:0] tx_level,
  output logic [CW-1:0] rx_level,
  output logic          busy,
`ifdef SPI_SEQ_XFER_CNT_EN
  output logic [15:0]   xfer_count,
`endif
  output logic          timeout_err,
  input  logic          err_clr,
  output logic          spi_start,
  output logic [7:0]    spi_data_in,
  input  logic [7:0]    spi_data_out,
  input  logic          spi_done
);

  localparam int              WW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0]   WDOG_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  seq_state_e    r_state;
  logic          r_spi_start;
  byte_t         r_spi_data_in;
  logic          r_timeout_err;
  logic [WW-1:0] r_wdog;

  byte_t         w_tx_head;
  logic          w_tx_full;
  logic          w_tx_empty;
  logic          w_rx_full;
  logic          w_rx_empty;
  logic          w_tx_pop;
  logic          w_rx_push;
  logic          w_can_launch;
  logic          w_timeout;

  spi_seq_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (tx_valid),
    .i_wr_data (tx_data),
    .i_pop     (w_tx_pop),
    .o_rd_data (w_tx_head),
    .o_full    (w_tx_full),
    .o_empty   (w_tx_empty),
    .o_level   (tx_level)
  );

  spi_seq_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_rx_push),
    .i_wr_data (spi_data_out),
    .i_pop     (rx_ready),
    .o_rd_data (rx_data),
    .o_full    (w_rx_full),
    .o_empty   (w_rx_empty),
    .o_level   (rx_level)
  );

  // A launch is only allowed with a free RX slot, so a returning byte can never be dropped.
  assign w_can_launch = enable && !w_tx_empty && !w_rx_full;
  assign w_tx_pop     = (r_state == LAUNCH);
  assign w_rx_push    = (r_state == WAIT) && spi_done;
  assign w_timeout    = (TIMEOUT != 0) && (r_state == WAIT) && !spi_done && (r_wdog == WDOG_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_spi_start   <= 1'b0;
      r_spi_data_in <= 8'h00;
      r_timeout_err <= 1'b0;
      r_wdog        <= '0;
    end else begin
      r_spi_start <= 1'b0;
      if (w_timeout)    r_timeout_err <= 1'b1;
      else if (err_clr) r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_can_launch) begin
            r_state       <= LAUNCH;
            r_spi_start   <= 1'b1;
            r_spi_data_in <= w_tx_head;
          end
        end
        LAUNCH: begin
          r_state <= WAIT;
          r_wdog  <= '0;
        end
        WAIT: begin
          if (spi_done || w_timeout) r_state <= IDLE;
          else                       r_wdog  <= r_wdog + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SPI_SEQ_XFER_CNT_EN
  logic [15:0] r_xfer_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_xfer_count <= 16'd0;
    else if (w_rx_push) r_xfer_count <= r_xfer_count + 16'd1;
  end

  assign xfer_count = r_xfer_count;
`endif

  assign tx_ready    = !w_tx_full;
  assign rx_valid    = !w_rx_empty;
  assign busy        = (r_state != IDLE);
  assign timeout_err = r_timeout_err;
  assign spi_start   = r_spi_start;
  assign spi_data_in = r_spi_data_in;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb/tb_spi_xfer_sequencer.sv - self-checking bench: instance A (DEPTH 8, TIMEOUT 1024), instance B (DEPTH 4, TIMEOUT 16)
`timescale 1ns/1ps
module tb_spi_xfer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  logic       a_rst = 1'b1, a_enable = 1'b0, a_tx_valid = 1'b0, a_rx_ready = 1'b0, a_err_clr = 1'b0, a_spi_done = 1'b0;
  logic [7:0] a_tx_data = 8'h00, a_spi_data_out = 8'h00;
  logic       a_tx_ready, a_rx_valid, a_busy, a_timeout_err, a_spi_start;
  logic [7:0] a_rx_data, a_spi_data_in;
  logic [3:0] a_tx_level, a_rx_level;

  logic       b_rst = 1'b1, b_enable = 1'b0, b_tx_valid = 1'b0, b_rx_ready = 1'b0, b_err_clr = 1'b0, b_spi_done = 1'b0;
  logic [7:0] b_tx_data = 8'h00, b_spi_data_out = 8'h00;
  logic       b_tx_ready, b_rx_valid, b_busy, b_timeout_err, b_spi_start;
  logic [7:0] b_rx_data, b_spi_data_in;
  logic [2:0] b_tx_level, b_rx_level;

`ifdef SPI_SEQ_XFER_CNT_EN
  logic [15:0] a_xfer_count, b_xfer_count;
`endif

  spi_xfer_sequencer #(.DEPTH(8), .TIMEOUT(1024)) dut_a (
    .clk(clk), .rst(a_rst), .enable(a_enable), .tx_data(a_tx_data), .tx_valid(a_tx_valid),
    .tx_ready(a_tx_ready), .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .tx_level(a_tx_level), .rx_level(a_rx_level), .busy(a_busy),
`ifdef SPI_SEQ_XFER_CNT_EN
    .xfer_count(a_xfer_count),
`endif
    .timeout_err(a_timeout_err), .err_clr(a_err_clr), .spi_start(a_spi_start),
    .spi_data_in(a_spi_data_in), .spi_data_out(a_spi_data_out), .spi_done(a_spi_done)
  );

  spi_xfer_sequencer #(.DEPTH(4), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst(b_rst), .enable(b_enable), .tx_data(b_tx_data), .tx_valid(b_tx_valid),
    .tx_ready(b_tx_ready), .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .tx_level(b_tx_level), .rx_level(b_rx_level), .busy(b_busy),
`ifdef SPI_SEQ_XFER_CNT_EN
    .xfer_count(b_xfer_count),
`endif
    .timeout_err(b_timeout_err), .err_clr(b_err_clr), .spi_start(b_spi_start),
    .spi_data_in(b_spi_data_in), .spi_data_out(b_spi_data_out), .spi_done(b_spi_done)
  );

  // SPI master models: done arrives lat cycles after the start cycle, reply = data ^ xor (or random).
  int         a_lat = 4, b_lat = 4, a_mcnt = 0, b_mcnt = 0;
  logic [7:0] a_xor = 8'h00, b_xor = 8'h00, a_mresp = 8'h00, b_mresp = 8'h00;
  bit         a_rand = 0, a_mbusy = 0, b_mbusy = 0, b_mute = 0;
  int         a_log_cyc[$], b_log_cyc[$];
  logic [7:0] a_log_dat[$], b_log_dat[$];

  always @(negedge clk) begin
    a_spi_done = 1'b0;
    if (a_mbusy) begin
      a_mcnt--;
      if (a_mcnt <= 0) begin
        a_spi_done = 1'b1; a_spi_data_out = a_mresp; a_mbusy = 0;
      end
    end
    if (a_spi_start) begin
      a_mbusy = 1;
      a_mcnt  = a_rand ? int'($urandom_range(1, 8)) : a_lat;
      a_mresp = a_rand ? 8'($urandom) : (a_spi_data_in ^ a_xor);
      a_log_cyc.push_back(cyc); a_log_dat.push_back(a_spi_data_in);
    end
  end

  always @(negedge clk) begin
    b_spi_done = 1'b0;
    if (b_mbusy) begin
      b_mcnt--;
      if (b_mcnt <= 0) begin
        b_spi_done = 1'b1; b_spi_data_out = b_mresp; b_mbusy = 0;
      end
    end
    if (b_spi_start) begin
      b_mbusy = !b_mute; b_mcnt = b_lat; b_mresp = b_spi_data_in ^ b_xor;
      b_log_cyc.push_back(cyc); b_log_dat.push_back(b_spi_data_in);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  function automatic bit sig_now(input int which);
    case (which)
      0: return a_spi_start;
      1: return a_rx_valid;
      2: return b_spi_start;
      default: return (a_tx_level == 0) && !a_busy;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int which, input int bound, output int c);
    c = -1;
    for (int i = 0; i < bound; i++) begin
      if (sig_now(which)) begin c = cyc; break; end
      adv(1);
    end
    if (c < 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: wait expired after %0d cycles", name, bound);
    end
  endtask

  typedef struct {
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       exp_tx_ready;
    logic [3:0] exp_tx_level;
  } vec_t;
  vec_t vt[10];

  logic [7:0] m_tx[$], m_rx[$];

  initial begin
    int s, s2, r, n;
    bit launch, exp_launch, inflight, push_ok, pop_rx;

    for (int i = 0; i < 9; i++) begin
      vt[i].tx_valid     = 1'b1;
      vt[i].tx_data      = 8'h40 + 8'(i);
      vt[i].exp_tx_level = 4'((i + 1 < 8) ? i + 1 : 8);
      vt[i].exp_tx_ready = (i + 1 < 8);
    end
    vt[9] = '{1'b0, 8'h00, 1'b0, 4'd8};

    adv(2);
    chk("rst_spi_start", a_spi_start, 0);
    chk("rst_spi_data_in", a_spi_data_in, 8'h00);
    chk("rst_tx_ready", a_tx_ready, 1);
    chk("rst_rx_valid", a_rx_valid, 0);
    chk("rst_tx_level", a_tx_level, 0);
    chk("rst_rx_level", a_rx_level, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_timeout_err", a_timeout_err, 0);
    chk("rst_b_tx_ready", b_tx_ready, 1);
    a_rst = 1'b0; b_rst = 1'b0;
    adv(1);

    // TX full: DEPTH+1 pushes with enable low
    for (int i = 0; i < 10; i++) begin
      a_tx_valid = vt[i].tx_valid; a_tx_data = vt[i].tx_data;
      adv(1);
      chk($sformatf("txfull_ready[%0d]", i), a_tx_ready, vt[i].exp_tx_ready);
      chk($sformatf("txfull_level[%0d]", i), a_tx_level, vt[i].exp_tx_level);
      chk($sformatf("txfull_busy[%0d]", i), a_busy, 0);
    end
    a_tx_valid = 1'b0;
    a_lat = 2; a_xor = 8'h00; a_log_cyc.delete(); a_log_dat.delete();
    a_enable = 1'b1;
    wait_sig("txfull_drain", 3, 200, r);
    a_enable = 1'b0;
    chk("txfull_launches", a_log_dat.size(), 8);
    for (int i = 0; i < a_log_dat.size() && i < 8; i++) chk($sformatf("txfull_order[%0d]", i), a_log_dat[i], 8'h40 + 8'(i));
    a_rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("txfull_rx[%0d]", i), a_rx_data, 8'h40 + 8'(i));
      adv(1);
    end
    a_rx_ready = 1'b0;
    chk("txfull_rx_empty", a_rx_level, 0);

    // Single byte
    a_lat = 40; a_xor = 8'hA5 ^ 8'h3C; a_log_cyc.delete(); a_log_dat.delete();
    a_enable = 1'b1; a_tx_valid = 1'b1; a_tx_data = 8'hA5; n = cyc;
    adv(1);
    a_tx_valid = 1'b0;
    wait_sig("single_start", 0, 10, s);
    chk("single_start_lat", s, n + 2);
    chk("single_data_in", a_spi_data_in, 8'hA5);
    adv(1);
    chk("single_tx_level", a_tx_level, 0);
    chk("single_busy", a_busy, 1);
    wait_sig("single_rx", 1, 60, r);
    chk("single_rx_lat", r, s + 41);
    chk("single_rx_data", a_rx_data, 8'h3C);
    chk("single_data_in_hold", a_spi_data_in, 8'hA5);
    a_rx_ready = 1'b1; adv(1); a_rx_ready = 1'b0;
    chk("single_rx_popped", a_rx_valid, 0);

    // Burst of four queued while disabled
    a_enable = 1'b0; a_lat = 10; a_xor = 8'h80; a_log_cyc.delete(); a_log_dat.delete();
    for (int i = 0; i < 4; i++) begin
      a_tx_valid = 1'b1; a_tx_data = 8'(i + 1); adv(1);
    end
    a_tx_valid = 1'b0;
    adv(3);
    chk("burst_queued", a_tx_level, 4);
    chk("burst_no_launch", a_log_dat.size(), 0);
    a_enable = 1'b1;
    wait_sig("burst_drain", 3, 200, r);
    adv(2);
    a_enable = 1'b0;
    chk("burst_launches", a_log_dat.size(), 4);
    for (int i = 0; i < a_log_dat.size() && i < 4; i++) begin
      chk($sformatf("burst_order[%0d]", i), a_log_dat[i], 8'(i + 1));
      if (i > 0) chk($sformatf("burst_spacing[%0d]", i), a_log_cyc[i] - a_log_cyc[i-1], 12);
    end
    a_rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("burst_rx[%0d]", i), a_rx_data, 8'(i + 1) ^ 8'h80);
      adv(1);
    end
    a_rx_ready = 1'b0;

    // Reset in the middle of a transfer
    a_lat = 40; a_xor = 8'h00; a_log_cyc.delete(); a_log_dat.delete();
    a_enable = 1'b1;
    a_tx_valid = 1'b1; a_tx_data = 8'h55; adv(1);
    a_tx_data = 8'h66; adv(1);
    a_tx_valid = 1'b0;
    wait_sig("rstmid_start", 0, 10, s);
    adv(5);
    chk("rstmid_busy_before", a_busy, 1);
    a_rst = 1'b1;
    #1;
    chk("rstmid_busy", a_busy, 0);
    chk("rstmid_spi_start", a_spi_start, 0);
    chk("rstmid_tx_level", a_tx_level, 0);
    chk("rstmid_rx_level", a_rx_level, 0);
    chk("rstmid_data_in", a_spi_data_in, 8'h00);
    chk("rstmid_tx_ready", a_tx_ready, 1);
    adv(1);
    a_rst = 1'b0;
    adv(45);
    chk("rstmid_late_done_rx", a_rx_level, 0);
    chk("rstmid_late_busy", a_busy, 0);
    chk("rstmid_launches", a_log_dat.size(), 1);

    // RX full back-pressure (B, DEPTH 4)
    b_lat = 3; b_xor = 8'h00; b_mute = 0; b_log_cyc.delete(); b_log_dat.delete();
    b_rx_ready = 1'b0; b_enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_tx_valid = 1'b1; b_tx_data = 8'h10 + 8'(i);
      for (int j = 0; j < 100 && !b_tx_ready; j++) adv(1);
      adv(1);
    end
    b_tx_valid = 1'b0;
    adv(60);
    chk("rxfull_launches", b_log_dat.size(), 4);
    chk("rxfull_rx_level", b_rx_level, 4);
    chk("rxfull_tx_level", b_tx_level, 2);
    chk("rxfull_busy", b_busy, 0);
    b_rx_ready = 1'b1; adv(1); b_rx_ready = 1'b0;
    adv(30);
    chk("rxfull_one_more", b_log_dat.size(), 5);
    chk("rxfull_rx_level2", b_rx_level, 4);
    chk("rxfull_tx_level2", b_tx_level, 1);
    b_rx_ready = 1'b1; adv(40); b_rx_ready = 1'b0;
    chk("rxfull_all", b_log_dat.size(), 6);
    chk("rxfull_drained", b_rx_level, 0);
    for (int i = 0; i < b_log_dat.size() && i < 6; i++) chk($sformatf("rxfull_order[%0d]", i), b_log_dat[i], 8'h10 + 8'(i));

    // Watchdog (B, TIMEOUT 16, silent master)
    b_mute = 1; b_log_cyc.delete(); b_log_dat.delete();
    b_tx_valid = 1'b1; b_tx_data = 8'h77; adv(1);
    b_tx_data = 8'h78; adv(1);
    b_tx_valid = 1'b0;
    wait_sig("wdog_start", 2, 10, s);
    adv(16);
    chk("wdog_flag_early", b_timeout_err, 0);
    chk("wdog_busy", b_busy, 1);
    adv(1);
    chk("wdog_flag", b_timeout_err, 1);
    chk("wdog_idle", b_busy, 0);
    chk("wdog_no_rx", b_rx_level, 0);
    adv(1);
    chk("wdog_next_start", b_spi_start, 1);
    chk("wdog_next_data", b_spi_data_in, 8'h78);
    b_err_clr = 1'b1; adv(1); b_err_clr = 1'b0;
    chk("wdog_clr", b_timeout_err, 0);
    adv(15);
    b_err_clr = 1'b1;
    chk("wdog_flag_pre2", b_timeout_err, 0);
    adv(1);
    b_err_clr = 1'b0;
    chk("wdog_clr_vs_timeout", b_timeout_err, 1);
    b_err_clr = 1'b1; adv(1); b_err_clr = 1'b0;
    chk("wdog_clr2", b_timeout_err, 0);
    chk("wdog_no_rx2", b_rx_level, 0);
    b_mute = 0; b_enable = 1'b0;

    // Randomised traffic against a queue model (A)
    a_rand = 1; exp_launch = 0; inflight = 0;
    m_tx.delete(); m_rx.delete();
    for (int k = 0; k < 3200; k++) begin
      adv(1);
      chk("rnd_tx_level", a_tx_level, m_tx.size());
      chk("rnd_rx_level", a_rx_level, m_rx.size());
      chk("rnd_tx_ready", a_tx_ready, m_tx.size() < 8);
      chk("rnd_rx_valid", a_rx_valid, m_rx.size() > 0);
      if (m_rx.size() > 0) chk("rnd_rx_data", a_rx_data, m_rx[0]);
      launch = a_spi_start;
      chk("rnd_launch", launch, exp_launch);
      chk("rnd_busy", a_busy, launch || inflight);
      if (launch && m_tx.size() > 0) chk("rnd_launch_data", a_spi_data_in, m_tx[0]);
      if (k < 3000) begin
        a_enable   = ($urandom_range(0, 9) < 8);
        a_tx_valid = $urandom_range(0, 1);
        a_tx_data  = 8'($urandom);
        a_rx_ready = ($urandom_range(0, 9) < 4);
      end else begin
        a_enable = 1'b1; a_tx_valid = 1'b0; a_rx_ready = 1'b1;
      end
      exp_launch = !launch && !inflight && a_enable && (m_tx.size() > 0) && (m_rx.size() < 8);
      push_ok = a_tx_valid && (m_tx.size() < 8);
      pop_rx  = a_rx_ready && (m_rx.size() > 0);
      if (launch && m_tx.size() > 0) void'(m_tx.pop_front());
      if (push_ok) m_tx.push_back(a_tx_data);
      if (pop_rx) void'(m_rx.pop_front());
      if (a_spi_done) m_rx.push_back(a_spi_data_out);
      inflight = launch ? 1'b1 : (a_spi_done ? 1'b0 : inflight);
    end
    a_tx_valid = 1'b0; a_rx_ready = 1'b0; a_enable = 1'b0;
    chk("rnd_final_tx", a_tx_level, 0);
    chk("rnd_final_rx", a_rx_level, 0);
    chk("rnd_final_err", a_timeout_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
